// File: rtl/cipher_seq_pkg.sv
// Shared types and constants for the cipher frame sequencer.
package cipher_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    CFG,
    CFG_GAP,
    EN,
    GAP,
    DONE
  } seq_state_t;

  localparam int CFG_GAP_CYCLES = 2;

  function automatic int cfg_len(input int m);
    return 2 * m + 2;
  endfunction

endpackage

// File: rtl/cipher_frame_sequencer_if.sv
// Pin bundle between the frame sequencer (master) and the dual XOR stream cipher (slave).
interface cipher_frame_sequencer_if;
  logic c_cfg_en;
  logic c_cfg_i;
  logic c_tx_en;
  logic c_tx_p;
  logic c_rx_en;
  logic c_rx_e;
  logic c_tx_e;
  logic c_rx_p;

  modport master (
    output c_cfg_en, c_cfg_i, c_tx_en, c_tx_p, c_rx_en, c_rx_e,
    input  c_tx_e, c_rx_p
  );

  modport slave (
    input  c_cfg_en, c_cfg_i, c_tx_en, c_tx_p, c_rx_en, c_rx_e,
    output c_tx_e, c_rx_p
  );
endinterface

// File: rtl/cipher_rr_arb2.sv
// Two-requester round-robin arbiter; the last-grant register starts on rx so tx wins first.
module cipher_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_tx,
  input  logic req_rx,
  output logic gnt_tx,
  output logic gnt_rx
);

  logic last_rx;

  always_comb begin
    gnt_tx = en & req_tx & (~req_rx | last_rx);
    gnt_rx = en & req_rx & (~req_tx | ~last_rx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rx <= 1'b1;
    end else if (gnt_tx | gnt_rx) begin
      last_rx <= gnt_rx;
    end
  end

endmodule

// File: rtl/cipher_frame_sequencer.sv
// Frame controller: arbitrates tx/rx requesters, optionally reloads the cipher config chain,
// then streams one W-bit frame through the cipher a bit at a time.
module cipher_frame_sequencer
  import cipher_seq_pkg::*;
#(
  parameter int M = 32,
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*M+1:0]       cfg_word,
  input  logic                 tx_req,
  input  logic                 rx_req,
  input  logic                 tx_rekey,
  input  logic                 rx_rekey,
  input  logic [W-1:0]         tx_data,
  input  logic [W-1:0]         rx_data,
  output logic                 tx_ack,
  output logic                 rx_ack,
  output logic                 done,
  output logic [W-1:0]         result,
  output logic                 result_dir,
  output logic                 busy,
  cipher_frame_sequencer_if.master cif
);

  localparam int CFG_LEN = cfg_len(M);
  localparam int CFG_CW  = $clog2(CFG_LEN);
  localparam int BIT_CW  = $clog2(W);

  seq_state_t          state_q, state_d;
  logic                dir_q;
  logic                cfg_valid_q;
  logic [CFG_CW-1:0]   cfg_cnt_q;
  logic [BIT_CW-1:0]   bit_cnt_q;
  logic [CFG_LEN-1:0]  cfg_q;
  logic [W-1:0]        data_q;
  logic [W-1:0]        acc_q;
  logic                gnt_tx, gnt_rx;
  logic                rekey_sel;
  logic                cur_bit;

  cipher_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == IDLE),
    .req_tx (tx_req),
    .req_rx (rx_req),
    .gnt_tx (gnt_tx),
    .gnt_rx (gnt_rx)
  );

  assign rekey_sel = dir_q ? rx_rekey : tx_rekey;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_tx | gnt_rx) state_d = GRANT;
      GRANT:   state_d = (rekey_sel || !cfg_valid_q) ? CFG : EN;
      CFG:     if (cfg_cnt_q == CFG_CW'(CFG_LEN - 1)) state_d = CFG_GAP;
      CFG_GAP: if (cfg_cnt_q == CFG_CW'(CFG_GAP_CYCLES - 1)) state_d = EN;
      EN:      state_d = GAP;
      GAP:     state_d = (bit_cnt_q == BIT_CW'(W - 1)) ? DONE : EN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers: state, direction, counters and the config-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      result      <= '0;
      result_dir  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (gnt_tx | gnt_rx)) dir_q <= gnt_rx;
      if (state_q == CFG && state_d == CFG_GAP) cfg_valid_q <= 1'b1;
      if (state_d != state_q) cfg_cnt_q <= '0;
      else if (state_q == CFG || state_q == CFG_GAP) cfg_cnt_q <= cfg_cnt_q + 1'b1;
      if (state_q == GRANT || state_q == CFG_GAP) bit_cnt_q <= '0;
      else if (state_q == GAP && state_d == EN) bit_cnt_q <= bit_cnt_q + 1'b1;
      if (state_q == GAP && state_d == DONE) begin
        result     <= acc_q;
        result_dir <= dir_q;
      end
    end
  end

  // Frame datapath: operands latched at grant, cipher output collected per EN cycle.
  always_ff @(posedge clk) begin
    if (state_q == GRANT) begin
      data_q <= dir_q ? rx_data : tx_data;
      cfg_q  <= cfg_word;
    end
    if (state_q == EN) acc_q[bit_cnt_q] <= dir_q ? cif.c_rx_p : cif.c_tx_e;
  end

  assign cur_bit = data_q[bit_cnt_q];

  assign tx_ack       = (state_q == GRANT) & ~dir_q;
  assign rx_ack       = (state_q == GRANT) & dir_q;
  assign done         = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign cif.c_cfg_en = (state_q == CFG);
  assign cif.c_cfg_i  = (state_q == CFG) & cfg_q[cfg_cnt_q];
  assign cif.c_tx_en  = (state_q == EN) & ~dir_q;
  assign cif.c_tx_p   = (state_q == EN) & ~dir_q & cur_bit;
  assign cif.c_rx_en  = (state_q == EN) & dir_q;
  assign cif.c_rx_e   = (state_q == EN) & dir_q & cur_bit;

endmodule
